// File: rtl/gpio_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a GPIO register block.
// Each granted access takes one ACCESS cycle on the GPIO side and one DONE
// cycle that returns ack/err/rdata to the winner, so accesses are at most
// one per three cycles with a fixed two-cycle request-to-ack latency.
module gpio_bus_arbiter #(
   parameter logic [31:0] ADDR_MAX = 32'h1C
) (
   input  logic        sysclk,
   input  logic        sysrst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        gpio_we,
   output logic [31:0] gpio_addr,
   output logic [31:0] gpio_wdata,
   input  logic [31:0] gpio_rdata,
   output logic        busy,
   output logic        grant
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   logic        ptr;        // requester that wins a tie
   logic        acc_we;     // latched direction of the access in flight
   logic        acc_legal;  // latched address legality of the access in flight

   logic        win_idx;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        win_legal;
   logic        any_req;
   logic        done_err;
   logic [31:0] done_rdata;

   // Word-aligned and inside the register window
   function automatic logic addr_legal(input logic [31:0] a);
      return (a <= ADDR_MAX) && (a[1:0] == 2'b00);
   endfunction

   assign any_req = m0_req | m1_req;

   // Winner selection: a lone requester always wins, a tie goes to the pointer holder
   always_comb begin
      win_idx = ptr;
      if (m0_req && !m1_req) begin
         win_idx = 1'b0;
      end else if (m1_req && !m0_req) begin
         win_idx = 1'b1;
      end
      win_we    = win_idx ? m1_we    : m0_we;
      win_addr  = win_idx ? m1_addr  : m0_addr;
      win_wdata = win_idx ? m1_wdata : m0_wdata;
      win_legal = addr_legal(win_addr);
   end

   // Completion values for the access finishing ACCESS this cycle; only legal reads return data
   always_comb begin
      done_err   = ~acc_legal;
      done_rdata = '0;
      if (acc_legal && !acc_we) begin
         done_rdata = gpio_rdata;
      end
   end

   // Control FSM with all outputs registered; reset aborts any access in flight
   always_ff @(posedge sysclk or negedge sysrst) begin
      if (!sysrst) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         grant      <= 1'b0;
         busy       <= 1'b0;
         acc_we     <= 1'b0;
         acc_legal  <= 1'b0;
         gpio_we    <= 1'b0;
         gpio_addr  <= '0;
         gpio_wdata <= '0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= ACCESS;
                  busy       <= 1'b1;
                  grant      <= win_idx;
                  acc_we     <= win_we;
                  acc_legal  <= win_legal;
                  gpio_addr  <= win_addr;
                  gpio_wdata <= win_wdata;
                  gpio_we    <= win_we & win_legal;
               end
            end

            ACCESS: begin
               state   <= DONE;
               gpio_we <= 1'b0;
               if (grant) begin
                  m1_ack   <= 1'b1;
                  m1_err   <= done_err;
                  m1_rdata <= done_rdata;
               end else begin
                  m0_ack   <= 1'b1;
                  m0_err   <= done_err;
                  m0_rdata <= done_rdata;
               end
            end

            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               ptr      <= ~grant;
               m0_ack   <= 1'b0;
               m0_err   <= 1'b0;
               m0_rdata <= '0;
               m1_ack   <= 1'b0;
               m1_err   <= 1'b0;
               m1_rdata <= '0;
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               gpio_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: expected completions and GPIO write strobes
// are queued as stimulus is issued and retired by a scoreboard monitor;
// each scenario task also checks timing and values inline.
`timescale 1ns/1ps
module tb_gpio_bus_arbiter;

   logic        sysclk = 1'b0;
   logic        sysrst = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        gpio_we, busy, grant;
   logic [31:0] gpio_addr, gpio_wdata, gpio_rdata;
   logic [31:0] rd_base = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic        idx;
      logic        err;
      logic [31:0] rdata;
   } ack_t;

   ack_t        ack_q[$];
   logic [63:0] st_q[$];

   // GPIO register block stand-in: read data is a known function of the address
   assign gpio_rdata = rd_base ^ gpio_addr;

   always #5 sysclk = ~sysclk;

   gpio_bus_arbiter #(.ADDR_MAX(32'h1C)) dut (
      .sysclk(sysclk), .sysrst(sysrst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .gpio_we(gpio_we), .gpio_addr(gpio_addr), .gpio_wdata(gpio_wdata),
      .gpio_rdata(gpio_rdata), .busy(busy), .grant(grant)
   );

   // Scoreboard: retire queued completions and write strobes as the DUT produces them
   always @(negedge sysclk) begin
      ack_t        e;
      ack_t        obs;
      logic [63:0] s;
      if (sysrst === 1'b1) begin
         if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            vectors++;
            obs = m1_ack ? ack_t'({1'b1, m1_err, m1_rdata}) : ack_t'({1'b0, m0_err, m0_rdata});
            if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
               miscompares++;
               $display("FAIL sb_dual_ack: both acks high at %0t, required one", $time);
            end else if (ack_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected_ack: got idx=%0b err=%0b rdata=%h, required none", obs.idx, obs.err, obs.rdata);
            end else begin
               e = ack_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL sb_ack: got idx=%0b err=%0b rdata=%h, required idx=%0b err=%0b rdata=%h",
                           obs.idx, obs.err, obs.rdata, e.idx, e.err, e.rdata);
               end
            end
         end
         vectors++;
         if ((m0_err === 1'b1 && m0_ack !== 1'b1) || (m1_err === 1'b1 && m1_ack !== 1'b1)) begin
            miscompares++;
            $display("FAIL sb_err_no_ack: m0 err/ack=%0b/%0b m1 err/ack=%0b/%0b, required err only with ack",
                     m0_err, m0_ack, m1_err, m1_ack);
         end
         if (gpio_we === 1'b1) begin
            vectors++;
            if (st_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected_strobe: addr=%h data=%h, required no strobe", gpio_addr, gpio_wdata);
            end else begin
               s = st_q.pop_front();
               if ({gpio_addr, gpio_wdata} !== s) begin
                  miscompares++;
                  $display("FAIL sb_strobe: addr=%h data=%h, required addr=%h data=%h",
                           gpio_addr, gpio_wdata, s[63:32], s[31:0]);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic apply_reset();
      m0_req = 1'b0;
      m1_req = 1'b0;
      sysrst = 1'b0;
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      sysrst = 1'b1;
      step();
   endtask

   // Issue one request and wait (bounded) for its ack; lat = -1 if none arrived
   task automatic do_access(input logic idx, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat,
                            output logic err, output logic [31:0] rdata);
      if (idx) begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end
      lat = -1;
      err = 1'b0;
      rdata = '0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if ((idx ? m1_ack : m0_ack) === 1'b1) begin
            lat   = i;
            err   = idx ? m1_err : m0_err;
            rdata = idx ? m1_rdata : m0_rdata;
            break;
         end
      end
      step();
      if (idx) m1_req = 1'b0; else m0_req = 1'b0;
   endtask

   task automatic test_reset();
      sysrst = 1'b0;
      step();
      step();
      vectors++;
      if ({gpio_we, m0_ack, m1_ack, m0_err, m1_err, busy, grant} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: we/ack0/ack1/err0/err1/busy/grant=%b, required 0000000",
                  {gpio_we, m0_ack, m1_ack, m0_err, m1_err, busy, grant});
      end
      vectors++;
      if ({gpio_addr, gpio_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h, required all 0",
                  gpio_addr, gpio_wdata, m0_rdata, m1_rdata);
      end
      @(negedge sysclk);
      sysrst = 1'b1;
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%0b, required 0", busy);
      end
   endtask

   task automatic test_write_m0();
      apply_reset();
      ack_q.push_back(ack_t'({1'b0, 1'b0, 32'h0}));
      st_q.push_back({32'h4, 32'hA5A5A5A5});
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4; m0_wdata = 32'hA5A5A5A5;
      step();
      vectors++;
      if (gpio_we !== 1'b1 || gpio_addr !== 32'h4 || gpio_wdata !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL wr_access: we=%0b addr=%h data=%h, required 1/00000004/a5a5a5a5", gpio_we, gpio_addr, gpio_wdata);
      end
      vectors++;
      if (busy !== 1'b1 || grant !== 1'b0 || m0_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_busy: busy=%0b grant=%0b ack=%0b, required 1/0/0", busy, grant, m0_ack);
      end
      step();
      vectors++;
      if (gpio_we !== 1'b0 || m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL wr_done: we=%0b ack=%0b err=%0b rdata=%h, required 0/1/0/0", gpio_we, m0_ack, m0_err, m0_rdata);
      end
      step();
      m0_req = 1'b0;
      vectors++;
      if (m0_ack !== 1'b0 || busy !== 1'b0 || gpio_addr !== 32'h4 || gpio_wdata !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL wr_after: ack=%0b busy=%0b addr=%h data=%h, required 0/0/00000004/a5a5a5a5",
                  m0_ack, busy, gpio_addr, gpio_wdata);
      end
   endtask

   task automatic test_read_m1();
      int          lat;
      logic        err;
      logic [31:0] rd;
      rd_base = 32'h12345678;
      ack_q.push_back(ack_t'({1'b1, 1'b0, 32'h12345678}));
      do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, err, rd);
      vectors++;
      if (lat != 2 || err !== 1'b0 || rd !== 32'h12345678 || grant !== 1'b1) begin
         miscompares++;
         $display("FAIL rd_m1: lat=%0d err=%0b rdata=%h grant=%0b, required 2/0/12345678/1", lat, err, rd, grant);
      end
   endtask

   task automatic test_round_robin();
      int       n0 = 0, n1 = 0, nacks = 0, last = -1;
      logic     drop0 = 1'b0, drop1 = 1'b0;
      logic [3:0] ord = 4'b0;
      apply_reset();
      rd_base = 32'hCAFE0000;
      ack_q.push_back(ack_t'({1'b0, 1'b0, 32'hCAFE0008}));
      ack_q.push_back(ack_t'({1'b1, 1'b0, 32'hCAFE0010}));
      ack_q.push_back(ack_t'({1'b0, 1'b0, 32'hCAFE0008}));
      ack_q.push_back(ack_t'({1'b1, 1'b0, 32'hCAFE0010}));
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
      for (int s = 1; s <= 14; s++) begin
         step();
         if (drop0) m0_req = 1'b0;
         if (drop1) m1_req = 1'b0;
         if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            if (last >= 0) begin
               vectors++;
               if (s - last != 3) begin
                  miscompares++;
                  $display("FAIL rr_spacing: ack gap=%0d cycles, required 3", s - last);
               end
            end
            last = s;
            if (nacks < 4) ord[nacks] = m1_ack;
            nacks++;
            if (m0_ack === 1'b1) begin n0++; if (n0 == 2) drop0 = 1'b1; end
            if (m1_ack === 1'b1) begin n1++; if (n1 == 2) drop1 = 1'b1; end
         end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (3) step();
      vectors++;
      if (nacks != 4 || ord !== 4'b1010) begin
         miscompares++;
         $display("FAIL rr_order: acks=%0d order(bit0 first)=%b, required 4/1010", nacks, ord);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] addrs [4] = '{32'h20, 32'h06, 32'h24, 32'h1C};
      logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic        errs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      int          lat;
      logic        err;
      logic [31:0] rd, exp_rd;
      rd_base = 32'h5A5A5A5A;
      for (int k = 0; k < 4; k++) begin
         exp_rd = (errs[k] || wes[k]) ? 32'h0 : (32'h5A5A5A5A ^ addrs[k]);
         ack_q.push_back(ack_t'({1'b0, errs[k], exp_rd}));
         do_access(1'b0, wes[k], addrs[k], 32'hFFFF_0000, lat, err, rd);
         vectors++;
         if (lat != 2 || err !== errs[k] || rd !== exp_rd) begin
            miscompares++;
            $display("FAIL illegal_%0d: addr=%h lat=%0d err=%0b rdata=%h, required 2/%0b/%h",
                     k, addrs[k], lat, err, rd, errs[k], exp_rd);
         end
      end
   endtask

   task automatic test_reset_abort();
      int          lat;
      int          stray = 0;
      logic        err;
      logic [31:0] rd;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'hDEADBEEF;
      step();
      vectors++;
      if (gpio_we !== 1'b1 || grant !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_access: we=%0b grant=%0b, required 1/1", gpio_we, grant);
      end
      #1 sysrst = 1'b0;
      #1;
      vectors++;
      if (gpio_we !== 1'b0 || busy !== 1'b0 || m1_ack !== 1'b0 || grant !== 1'b0 || gpio_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL abort_immediate: we=%0b busy=%0b ack=%0b grant=%0b addr=%h, required 0/0/0/0/0",
                  gpio_we, busy, m1_ack, grant, gpio_addr);
      end
      m1_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (m1_ack !== 1'b0) stray++;
      end
      @(negedge sysclk);
      sysrst = 1'b1;
      step();
      if (m1_ack !== 1'b0) stray++;
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL abort_no_ack: stray acks=%0d, required 0", stray);
      end
      ack_q.push_back(ack_t'({1'b1, 1'b0, 32'h0}));
      st_q.push_back({32'h8, 32'hDEADBEEF});
      do_access(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, lat, err, rd);
      vectors++;
      if (lat != 2 || err !== 1'b0 || grant !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_retry: lat=%0d err=%0b grant=%0b, required 2/0/1", lat, err, grant);
      end
   endtask

   task automatic test_back_to_back();
      int   na = 0, ns = 0;
      int   st_at [2] = '{-1, -1};
      logic chg = 1'b0, drop = 1'b0;
      ack_q.push_back(ack_t'({1'b0, 1'b0, 32'h0}));
      ack_q.push_back(ack_t'({1'b0, 1'b0, 32'h0}));
      st_q.push_back({32'h0C, 32'hFF});
      st_q.push_back({32'h10, 32'hFF});
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0C; m0_wdata = 32'hFF;
      for (int s = 1; s <= 10; s++) begin
         step();
         if (chg) begin m0_addr = 32'h10; chg = 1'b0; end
         if (drop) begin m0_req = 1'b0; drop = 1'b0; end
         if (gpio_we === 1'b1) begin
            if (ns < 2) st_at[ns] = s;
            ns++;
         end
         if (m0_ack === 1'b1) begin
            na++;
            if (na == 1) chg = 1'b1;
            if (na == 2) drop = 1'b1;
         end
      end
      m0_req = 1'b0;
      vectors++;
      if (ns != 2 || na != 2 || st_at[1] - st_at[0] != 3) begin
         miscompares++;
         $display("FAIL b2b: strobes=%0d acks=%0d strobe cycles=%0d,%0d, required 2/2 gap 3",
                  ns, na, st_at[0], st_at[1]);
      end
   endtask

   initial begin
      test_reset();
      test_write_m0();
      test_read_m1();
      test_round_robin();
      test_illegal();
      test_reset_abort();
      test_back_to_back();
      repeat (3) step();
      vectors++;
      if (ack_q.size() != 0 || st_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: acks pending=%0d strobes pending=%0d, required 0/0", ack_q.size(), st_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
